loopback_router: RTL and testbench
==================================

// Module: loopback_router
// PURPOSE
// Buffered, arbitrated successor of the loopback path between post office, comm interface and mailbox.
// Self-addressed sends (dest == local_address) enter a LOOPBACK_DEPTH FIFO; all other sends pass to the interface.
// The FIFO head and interface receive traffic share the mailbox port through a locked, selectable arbiter.
// Adds a saturating loopback message counter and FIFO occupancy for performance counters.
// PARAMETERS
// LOOPBACK_DEPTH  4   loopback FIFO entries; power of two, >= 2
// ENABLE_LOOPBACK 1   0: never intercept; every send goes to the interface and the FIFO stays empty
// ARB_MODE        0   0: round-robin between FIFO and remote receive; 1: remote receive strictly first
// CNT_W           16  width of loopback_count
// PORTS
// clk_i                      in   1                                  clock
// rstn_i                     in   1                                  synchronous reset, active low
// local_address              in   $bits(message_addr_t)              this node's address
// postoffice_loopback_valid  in   1                                  post office send valid
// loopback_postoffice_ready  out  1                                  send accepted
// postoffice_loopback_data   in   $bits(interface_send_data_t)       send payload
// loopback_interface_valid   out  1                                  remote send valid
// interface_loopback_ready   in   1                                  interface accepts send
// loopback_interface_data    out  $bits(interface_send_data_t)       always = postoffice_loopback_data
// loopback_mailbox_valid     out  1                                  delivery to mailbox valid
// mailbox_loopback_ready     in   1                                  mailbox accepts
// loopback_mailbox_data      out  $bits(interface_receive_data_t)    delivered message
// interface_loopback_valid   in   1                                  remote receive valid
// loopback_interface_ready   out  1                                  remote receive accepted
// interface_loopback_data    in   $bits(interface_send_data_t)       remote receive payload
// loopback_fifo_count        out  $clog2(LOOPBACK_DEPTH)+1           FIFO occupancy
// loopback_count             out  CNT_W                              messages looped back, saturating
// BEHAVIOUR
// - Reset (rstn_i low at posedge): FIFO emptied, rd/wr pointers 0, count 0, loopback_count 0, lock 0,
//   last_grant=FIFO, so remote wins the first tie. Outputs after reset: all valid/ready 0 except as derived below.
// - is_self = ENABLE_LOOPBACK && meta.address == local_address. The decode is combinational on the current data.
// - Send, is_self=0: loopback_interface_valid=postoffice_loopback_valid. loopback_postoffice_ready=interface_loopback_ready.
//   Zero latency, no storage.
// - Send, is_self=1: loopback_interface_valid=0. loopback_postoffice_ready=(count<LOOPBACK_DEPTH).
//   Push on valid&&ready. Full-check ignores a same-cycle pop; there is no full bypass.
// - FIFO: no fall-through. A push at edge N is visible at the mailbox from cycle N+1, so minimum loopback latency is 1 cycle.
//   Push and pop in the same cycle leave count unchanged. Pointers wrap modulo LOOPBACK_DEPTH.
// - Arbiter requests: rq_l=(count!=0), rq_r=interface_loopback_valid. grant is chosen when unlocked:
//   ARB_MODE=0 -> the single requester, or !last_grant on a tie. ARB_MODE=1 -> remote whenever rq_r.
// - Lock: if loopback_mailbox_valid && !mailbox_loopback_ready, the current grant is held next cycle.
//   Data and valid stay stable until the handshake (AXI-style). Lock clears on handshake.
//   If the remote source drops valid while locked, the violation is on the interface side and is not recovered.
// - Mailbox outputs: loopback_mailbox_valid = granted request. loopback_mailbox_data = FIFO head or interface data per grant.
//   loopback_interface_ready = (grant==REMOTE) && mailbox_loopback_ready.
//   Pop when grant==FIFO and handshake. last_grant updates only on a handshake.
// - loopback_count += 1 per FIFO pop and saturates at 2^CNT_W-1.
// - Reset mid-operation discards FIFO contents. Only in-flight loopback messages are lost.
// TESTING
// 1 local=5, send dest=7, iface_ready=1 -> iface_valid same cycle, postoffice_ready=1, FIFO count stays 0.
// 2 local=5, 4 back-to-back sends dest=5, mailbox_ready=0 -> count 1..4, 5th send stalls (ready=0);
//   mailbox_ready=1 -> delivered in order, 1 per cycle.
// 3 FIFO holds 2, remote valid held, ARB_MODE=0 -> deliveries alternate R,L,R,L starting with remote.
// 4 Mailbox stalls 3 cycles while presenting a FIFO entry, remote valid rises -> grant and data unchanged until handshake.
// 5 ENABLE_LOOPBACK=0, dest=local -> routed to interface, loopback_count stays 0.
// 6 CNT_W=2, 5 loopbacks -> loopback_count saturates at 3. rstn_i low with 2 entries -> count 0, mailbox_valid 0 next cycle.

Source files
------------

// File: rtl/loopback_router.sv
`default_nettype none
// ============================================================================
// Module      : loopback_router
// Description : Routes post-office sends either to the comm interface or,
//               when self-addressed, into a loopback FIFO. The FIFO head and
//               remote receive traffic share the mailbox port through a
//               locked arbiter (round-robin or remote-first). Also exports
//               FIFO occupancy and a saturating loopback message counter.
// Revision    : 1.0 - initial release
// ============================================================================
module loopback_router #(
    parameter int LOOPBACK_DEPTH  = 4,
    parameter int ENABLE_LOOPBACK = 1,
    parameter int ARB_MODE        = 0,
    parameter int CNT_W           = 16,
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 32
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [ADDR_W-1:0]                 local_address,
    input  logic                              postoffice_loopback_valid,
    output logic                              loopback_postoffice_ready,
    input  logic [DATA_W-1:0]                 postoffice_loopback_data,
    output logic                              loopback_interface_valid,
    input  logic                              interface_loopback_ready,
    output logic [DATA_W-1:0]                 loopback_interface_data,
    output logic                              loopback_mailbox_valid,
    input  logic                              mailbox_loopback_ready,
    output logic [DATA_W-1:0]                 loopback_mailbox_data,
    input  logic                              interface_loopback_valid,
    output logic                              loopback_interface_ready,
    input  logic [DATA_W-1:0]                 interface_loopback_data,
    output logic [$clog2(LOOPBACK_DEPTH):0]   loopback_fifo_count,
    output logic [CNT_W-1:0]                  loopback_count
);

    localparam int PTR_W = $clog2(LOOPBACK_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Grant encoding: one bit, FIFO = 0, remote receive = 1
    localparam logic [0:0] GRANT_FIFO   = 1'b0;
    localparam logic [0:0] GRANT_REMOTE = 1'b1;

    localparam logic [OCC_W-1:0] C_FULL  = OCC_W'(LOOPBACK_DEPTH);
    localparam logic [CNT_W-1:0] C_SAT   = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_mem [LOOPBACK_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_lb_count;
    logic              r_lock;
    logic [0:0]        r_lock_sel;
    logic [0:0]        r_last_grant;

    logic              w_is_self;
    logic              w_not_full;
    logic              w_push;
    logic              w_pop;
    logic              w_rq_l;
    logic              w_rq_r;
    logic [0:0]        w_sel;
    logic              w_mb_valid;
    logic              w_handshake;

    // Destination lives in the top ADDR_W bits of the message
    assign w_is_self  = (ENABLE_LOOPBACK != 0) &&
                        (postoffice_loopback_data[DATA_W-1 -: ADDR_W] == local_address);
    // Full check deliberately ignores a same-cycle pop (no full bypass)
    assign w_not_full = (r_occ != C_FULL);

    assign loopback_interface_valid  = postoffice_loopback_valid && !w_is_self;
    assign loopback_interface_data   = postoffice_loopback_data;
    assign loopback_postoffice_ready = w_is_self ? w_not_full : interface_loopback_ready;
    assign w_push                    = postoffice_loopback_valid && w_is_self && w_not_full;

    assign w_rq_l = (r_occ != '0);
    assign w_rq_r = interface_loopback_valid;

    // Arbitration: a held grant while locked, otherwise mode-dependent choice
    always_comb begin
        w_sel = GRANT_FIFO;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (ARB_MODE == 1) begin
            w_sel = w_rq_r ? GRANT_REMOTE : GRANT_FIFO;
        end else if (w_rq_r && w_rq_l) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = w_rq_r ? GRANT_REMOTE : GRANT_FIFO;
        end
    end

    assign w_mb_valid  = (w_sel == GRANT_REMOTE) ? w_rq_r : w_rq_l;
    assign w_handshake = w_mb_valid && mailbox_loopback_ready;
    assign w_pop       = w_handshake && (w_sel == GRANT_FIFO);

    assign loopback_mailbox_valid   = w_mb_valid;
    assign loopback_mailbox_data    = (w_sel == GRANT_REMOTE) ? interface_loopback_data
                                                              : r_mem[r_rd_ptr];
    assign loopback_interface_ready = (w_sel == GRANT_REMOTE) && mailbox_loopback_ready;
    assign loopback_fifo_count      = r_occ;
    assign loopback_count           = r_lb_count;

    // FIFO storage: contents need no reset, occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= postoffice_loopback_data;
        end
    end

    // FIFO pointers, occupancy and the saturating loopback counter
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_occ      <= '0;
            r_lb_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_lb_count != C_SAT) begin
                    r_lb_count <= r_lb_count + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Grant lock across a stalled mailbox and round-robin history
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_lock       <= 1'b0;
            r_lock_sel   <= GRANT_FIFO;
            r_last_grant <= GRANT_FIFO;
        end else begin
            r_lock     <= w_mb_valid && !mailbox_loopback_ready;
            r_lock_sel <= w_sel;
            if (w_handshake) begin
                r_last_grant <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loopback_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_loopback_router
// Description : Directed self-checking bench for loopback_router. Four
//               instances share one stimulus: default, loopback disabled,
//               2-bit counter, and remote-first arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loopback_router;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  local_address;
    logic        po_valid;
    logic [31:0] po_data;
    logic        if_ready;
    logic        mb_ready;
    logic        if_valid;
    logic [31:0] if_data;

    logic        po_ready_a, ifo_valid_a, mb_valid_a, ifo_ready_a;
    logic [31:0] ifo_data_a, mb_data_a;
    logic [2:0]  fifo_count_a;
    logic [15:0] lb_count_a;

    logic        po_ready_b, ifo_valid_b, mb_valid_b, ifo_ready_b;
    logic [31:0] ifo_data_b, mb_data_b;
    logic [2:0]  fifo_count_b;
    logic [15:0] lb_count_b;

    logic        po_ready_c, ifo_valid_c, mb_valid_c, ifo_ready_c;
    logic [31:0] ifo_data_c, mb_data_c;
    logic [2:0]  fifo_count_c;
    logic [1:0]  lb_count_c;

    logic        po_ready_d, ifo_valid_d, mb_valid_d, ifo_ready_d;
    logic [31:0] ifo_data_d, mb_data_d;
    logic [2:0]  fifo_count_d;
    logic [15:0] lb_count_d;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    loopback_router #(.LOOPBACK_DEPTH(4), .ENABLE_LOOPBACK(1), .ARB_MODE(0), .CNT_W(16)) u_a (
        .clk_i(clk), .rstn_i(rstn), .local_address(local_address),
        .postoffice_loopback_valid(po_valid), .loopback_postoffice_ready(po_ready_a),
        .postoffice_loopback_data(po_data), .loopback_interface_valid(ifo_valid_a),
        .interface_loopback_ready(if_ready), .loopback_interface_data(ifo_data_a),
        .loopback_mailbox_valid(mb_valid_a), .mailbox_loopback_ready(mb_ready),
        .loopback_mailbox_data(mb_data_a), .interface_loopback_valid(if_valid),
        .loopback_interface_ready(ifo_ready_a), .interface_loopback_data(if_data),
        .loopback_fifo_count(fifo_count_a), .loopback_count(lb_count_a));

    loopback_router #(.LOOPBACK_DEPTH(4), .ENABLE_LOOPBACK(0), .ARB_MODE(0), .CNT_W(16)) u_b (
        .clk_i(clk), .rstn_i(rstn), .local_address(local_address),
        .postoffice_loopback_valid(po_valid), .loopback_postoffice_ready(po_ready_b),
        .postoffice_loopback_data(po_data), .loopback_interface_valid(ifo_valid_b),
        .interface_loopback_ready(if_ready), .loopback_interface_data(ifo_data_b),
        .loopback_mailbox_valid(mb_valid_b), .mailbox_loopback_ready(mb_ready),
        .loopback_mailbox_data(mb_data_b), .interface_loopback_valid(if_valid),
        .loopback_interface_ready(ifo_ready_b), .interface_loopback_data(if_data),
        .loopback_fifo_count(fifo_count_b), .loopback_count(lb_count_b));

    loopback_router #(.LOOPBACK_DEPTH(4), .ENABLE_LOOPBACK(1), .ARB_MODE(0), .CNT_W(2)) u_c (
        .clk_i(clk), .rstn_i(rstn), .local_address(local_address),
        .postoffice_loopback_valid(po_valid), .loopback_postoffice_ready(po_ready_c),
        .postoffice_loopback_data(po_data), .loopback_interface_valid(ifo_valid_c),
        .interface_loopback_ready(if_ready), .loopback_interface_data(ifo_data_c),
        .loopback_mailbox_valid(mb_valid_c), .mailbox_loopback_ready(mb_ready),
        .loopback_mailbox_data(mb_data_c), .interface_loopback_valid(if_valid),
        .loopback_interface_ready(ifo_ready_c), .interface_loopback_data(if_data),
        .loopback_fifo_count(fifo_count_c), .loopback_count(lb_count_c));

    loopback_router #(.LOOPBACK_DEPTH(4), .ENABLE_LOOPBACK(1), .ARB_MODE(1), .CNT_W(16)) u_d (
        .clk_i(clk), .rstn_i(rstn), .local_address(local_address),
        .postoffice_loopback_valid(po_valid), .loopback_postoffice_ready(po_ready_d),
        .postoffice_loopback_data(po_data), .loopback_interface_valid(ifo_valid_d),
        .interface_loopback_ready(if_ready), .loopback_interface_data(ifo_data_d),
        .loopback_mailbox_valid(mb_valid_d), .mailbox_loopback_ready(mb_ready),
        .loopback_mailbox_data(mb_data_d), .interface_loopback_valid(if_valid),
        .loopback_interface_ready(ifo_ready_d), .interface_loopback_data(if_data),
        .loopback_fifo_count(fifo_count_d), .loopback_count(lb_count_d));

    function automatic logic [31:0] mk(input logic [7:0] dest, input logic [23:0] payload);
        return {dest, payload};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn          = 1'b0;
        local_address = 8'd5;
        po_valid      = 1'b0;
        po_data       = '0;
        if_ready      = 1'b0;
        mb_ready      = 1'b0;
        if_valid      = 1'b0;
        if_data       = '0;

        // Reset state
        tick();
        tick();
        rstn = 1'b1;
        #1;
        chk("rst_fifo_count", 32'(fifo_count_a), 0);
        chk("rst_lb_count",   32'(lb_count_a), 0);
        chk("rst_mb_valid",   32'(mb_valid_a), 0);
        chk("rst_ifo_ready",  32'(ifo_ready_a), 0);
        chk("rst_po_ready",   32'(po_ready_a), 0);

        // Remote send passes straight through to the interface
        po_valid = 1'b1;
        po_data  = mk(8'd7, 24'h000111);
        if_ready = 1'b1;
        #1;
        chk("t1_ifo_valid", 32'(ifo_valid_a), 1);
        chk("t1_po_ready",  32'(po_ready_a), 1);
        chk("t1_ifo_data",  ifo_data_a, mk(8'd7, 24'h000111));
        chk("t1_mb_valid",  32'(mb_valid_a), 0);
        tick();
        chk("t1_fifo_count", 32'(fifo_count_a), 0);

        // Four self-addressed sends fill the FIFO while the mailbox stalls
        for (int i = 0; i < 4; i++) begin
            po_data = mk(8'd5, 24'h0000A0 + 24'(i));
            #1;
            chk("t2_po_ready",   32'(po_ready_a), 1);
            chk("t2_ifo_valid",  32'(ifo_valid_a), 0);
            chk("t5_ifo_valid",  32'(ifo_valid_b), 1);
            tick();
            chk("t2_fifo_count", 32'(fifo_count_a), 32'(i + 1));
            chk("t2_head_valid", 32'(mb_valid_a), 1);
            chk("t2_head_data",  mb_data_a, mk(8'd5, 24'h0000A0));
        end
        po_data = mk(8'd5, 24'h0000A4);
        #1;
        chk("t2_full_stall", 32'(po_ready_a), 0);
        tick();
        chk("t2_full_hold",  32'(fifo_count_a), 4);
        po_valid = 1'b0;
        mb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_drain_valid", 32'(mb_valid_a), 1);
            chk("t2_drain_data",  mb_data_a, mk(8'd5, 24'h0000A0 + 24'(i)));
            tick();
        end
        chk("t2_empty_count", 32'(fifo_count_a), 0);
        chk("t2_empty_valid", 32'(mb_valid_a), 0);
        chk("t2_lb_count",    32'(lb_count_a), 4);
        chk("t6_lb_sat",      32'(lb_count_c), 3);

        // Two FIFO entries compete with a held remote receive
        mb_ready = 1'b0;
        if_valid = 1'b1;
        if_data  = 32'hCC000001;
        po_valid = 1'b1;
        po_data  = mk(8'd5, 24'h0000B0);
        tick();
        po_data  = mk(8'd5, 24'h0000B1);
        tick();
        po_valid = 1'b0;
        mb_ready = 1'b1;
        #1;
        chk("t3_r1_data",  mb_data_a, 32'hCC000001);
        chk("t3_r1_ready", 32'(ifo_ready_a), 1);
        chk("t3_d1_data",  mb_data_d, 32'hCC000001);
        tick();
        chk("t3_l1_data",  mb_data_a, mk(8'd5, 24'h0000B0));
        chk("t3_l1_ready", 32'(ifo_ready_a), 0);
        chk("t3_d2_data",  mb_data_d, 32'hCC000001);
        chk("t3_d2_ready", 32'(ifo_ready_d), 1);
        tick();
        chk("t3_r2_data",  mb_data_a, 32'hCC000001);
        tick();
        chk("t3_l2_data",  mb_data_a, mk(8'd5, 24'h0000B1));
        tick();
        if_valid = 1'b0;
        #1;
        chk("t3_fifo_count", 32'(fifo_count_a), 0);
        chk("t3_mb_valid",   32'(mb_valid_a), 0);

        // Stalled FIFO delivery keeps its grant when remote valid rises
        mb_ready = 1'b0;
        po_valid = 1'b1;
        po_data  = mk(8'd5, 24'h0000D0);
        tick();
        po_valid = 1'b0;
        #1;
        chk("t4_stall0_data", mb_data_a, mk(8'd5, 24'h0000D0));
        tick();
        if_valid = 1'b1;
        if_data  = 32'hEE000002;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_hold_data",  mb_data_a, mk(8'd5, 24'h0000D0));
            chk("t4_hold_ready", 32'(ifo_ready_a), 0);
            chk("t4_hold_valid", 32'(mb_valid_a), 1);
            tick();
        end
        mb_ready = 1'b1;
        #1;
        chk("t4_hs_data",  mb_data_a, mk(8'd5, 24'h0000D0));
        chk("t4_hs_ready", 32'(ifo_ready_a), 0);
        tick();
        chk("t4_remote_data",  mb_data_a, 32'hEE000002);
        chk("t4_remote_ready", 32'(ifo_ready_a), 1);
        chk("t4_fifo_count",   32'(fifo_count_a), 0);
        tick();
        if_valid = 1'b0;
        #1;
        chk("t4_lb_count", 32'(lb_count_a), 7);

        // Disabled loopback never counts; reset with two entries queued
        mb_ready = 1'b0;
        po_valid = 1'b1;
        po_data  = mk(8'd5, 24'h0000E0);
        tick();
        po_data  = mk(8'd5, 24'h0000E1);
        tick();
        po_valid = 1'b0;
        #1;
        chk("t6_pre_count",  32'(fifo_count_a), 2);
        chk("t6_sat_hold",   32'(lb_count_c), 3);
        chk("t5_lb_count",   32'(lb_count_b), 0);
        chk("t5_fifo_count", 32'(fifo_count_b), 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("t6_rst_count",   32'(fifo_count_a), 0);
        chk("t6_rst_valid",   32'(mb_valid_a), 0);
        chk("t6_rst_lb",      32'(lb_count_a), 0);
        chk("t6_rst_lb_c",    32'(lb_count_c), 0);
        mb_ready = 1'b1;
        tick();
        chk("t6_post_valid",  32'(mb_valid_a), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
